// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - client, writeback and memory-port signals of the line arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 8
);
    localparam int BEAT_W = $clog2(LINE_WORDS);

    logic                     ic_req;
    logic [ADDR_W-1:0]        ic_addr;
    logic                     ic_beat_valid;
    logic [31:0]              ic_rdata;
    logic [BEAT_W-1:0]        ic_beat;
    logic                     ic_done;

    logic                     dc_req;
    logic [ADDR_W-1:0]        dc_addr;
    logic                     dc_beat_valid;
    logic [31:0]              dc_rdata;
    logic [BEAT_W-1:0]        dc_beat;
    logic                     dc_done;

    logic                     wb_valid;
    logic                     wb_ready;
    logic [ADDR_W-1:0]        wb_addr;
    logic [32*LINE_WORDS-1:0] wb_data;

    logic                     mem_req;
    logic                     mem_we;
    logic [ADDR_W-1:0]        mem_addr;
    logic [31:0]              mem_wdata;
    logic                     mem_ack;
    logic [31:0]              mem_rdata;

    logic                     busy;

    modport slave (
        input  ic_req, ic_addr, dc_req, dc_addr,
        input  wb_valid, wb_addr, wb_data, mem_ack, mem_rdata,
        output ic_beat_valid, ic_rdata, ic_beat, ic_done,
        output dc_beat_valid, dc_rdata, dc_beat, dc_done,
        output wb_ready, mem_req, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output ic_req, ic_addr, dc_req, dc_addr,
        output wb_valid, wb_addr, wb_data, mem_ack, mem_rdata,
        input  ic_beat_valid, ic_rdata, ic_beat, ic_done,
        input  dc_beat_valid, dc_rdata, dc_beat, dc_done,
        input  wb_ready, mem_req, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IC/DC refill and writeback arbiter for one word-wide memory port
// Define ARB_RR_EN for round-robin DC/IC fill selection; default is fixed WB > DC > IC.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 8,
    parameter int OFST_W     = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_port_arbiter_if.slave     bus
);
    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((64'd1 << OFST_W) - 64'd1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, WB, DC_FILL, IC_FILL} state_t;

    state_t                   state_q, state_d;
    logic [BEAT_W-1:0]        beat_q, beat_d;
    logic                     req_q, req_d;
    logic [ADDR_W-1:0]        line_q, line_d;
    logic                     buf_full_q;
    logic [ADDR_W-1:0]        buf_addr_q;
    logic [32*LINE_WORDS-1:0] buf_data_q;

    logic wb_accept, wb_pending, ack, last, grant_dc, ic_valid, dc_valid;

    assign wb_accept  = bus.wb_valid & ~buf_full_q;
    // A line accepted this cycle already outranks a refill, keeping a same-line DC refill behind it.
    assign wb_pending = buf_full_q | wb_accept;
    assign ack        = req_q & bus.mem_ack;
    assign last       = (beat_q == LAST_BEAT);

`ifdef ARB_RR_EN
    logic last_fill_q, last_fill_d;

    assign grant_dc = bus.dc_req & (~bus.ic_req | ~last_fill_q);

    always_comb begin
        last_fill_d = last_fill_q;
        if (state_q == IDLE && !wb_pending) begin
            if (grant_dc)
                last_fill_d = 1'b1;
            else if (bus.ic_req)
                last_fill_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) last_fill_q <= 1'b0;
        else        last_fill_q <= last_fill_d;
    end
`else
    assign grant_dc = bus.dc_req;
`endif

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        req_d   = req_q;
        line_d  = line_q;
        case (state_q)
            IDLE: begin
                if (wb_pending) begin
                    state_d = WB;
                    line_d  = buf_full_q ? buf_addr_q : (bus.wb_addr & LINE_MASK);
                end else if (grant_dc) begin
                    state_d = DC_FILL;
                    line_d  = bus.dc_addr & LINE_MASK;
                end else if (bus.ic_req) begin
                    state_d = IC_FILL;
                    line_d  = bus.ic_addr & LINE_MASK;
                end
                beat_d = '0;
                req_d  = wb_pending | bus.dc_req | bus.ic_req;
            end
            default: begin
                if (ack) begin
                    beat_d = beat_q + BEAT_W'(1);
                    req_d  = 1'b0;
                    if (last) state_d = IDLE;
                end else if (!req_q) begin
                    req_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            req_q   <= 1'b0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            req_q   <= req_d;
            line_q  <= line_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_full_q <= 1'b0;
            buf_addr_q <= '0;
            buf_data_q <= '0;
        end else if (wb_accept) begin
            buf_full_q <= 1'b1;
            buf_addr_q <= bus.wb_addr & LINE_MASK;
            buf_data_q <= bus.wb_data;
        end else if (state_q == WB && ack && last) begin
            buf_full_q <= 1'b0;
        end
    end

    assign ic_valid = ack & (state_q == IC_FILL);
    assign dc_valid = ack & (state_q == DC_FILL);

    assign bus.mem_req   = req_q;
    assign bus.mem_we    = (state_q == WB);
    assign bus.mem_addr  = line_q | (ADDR_W'(beat_q) << (OFST_W - BEAT_W));
    assign bus.mem_wdata = (state_q == WB) ? buf_data_q[beat_q*32 +: 32] : 32'd0;
    assign bus.wb_ready  = ~buf_full_q;
    assign bus.busy      = (state_q != IDLE) | buf_full_q;

    assign bus.ic_beat_valid = ic_valid;
    assign bus.ic_rdata      = ic_valid ? bus.mem_rdata : 32'd0;
    assign bus.ic_beat       = ic_valid ? beat_q : '0;
    assign bus.ic_done       = ic_valid & last;

    assign bus.dc_beat_valid = dc_valid;
    assign bus.dc_rdata      = dc_valid ? bus.mem_rdata : 32'd0;
    assign bus.dc_beat       = dc_valid ? beat_q : '0;
    assign bus.dc_done       = dc_valid & last;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mem_port_arbiter_if #(.ADDR_W(32), .LINE_WORDS(8)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .LINE_WORDS(8), .OFST_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // owner: 0 = writeback (no fill delivery), 1 = IC, 2 = DC
    task automatic run_line(input string tag, input logic [31:0] base, input bit we,
                            input int owner, input logic [255:0] line,
                            input logic [31:0] rd_base, input int nbeats,
                            input int stall_beat, input bit drop_reqs);
        for (int k = 0; k < nbeats; k++) begin
            int n;
            n = 0;
            while (!bus.mem_req && n < 20) begin
                @(negedge clk); #1;
                n++;
            end
            chk({tag, " req_timeout"}, 64'(n < 20), 64'(1));
            chk({tag, " addr"}, 64'(bus.mem_addr), 64'(base + 32'(4 * k)));
            chk({tag, " we"}, 64'(bus.mem_we), 64'(we));
            chk({tag, " wdata"}, 64'(bus.mem_wdata), we ? 64'(line[k*32 +: 32]) : 64'(0));
            if (k == stall_beat) begin
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk); #1;
                    chk({tag, " stall_req"}, 64'(bus.mem_req), 64'(1));
                    chk({tag, " stall_addr"}, 64'(bus.mem_addr), 64'(base + 32'(4 * k)));
                    chk({tag, " stall_wdata"}, 64'(bus.mem_wdata), we ? 64'(line[k*32 +: 32]) : 64'(0));
                    chk({tag, " stall_valid"}, 64'({bus.ic_beat_valid, bus.dc_beat_valid}), 64'(0));
                end
            end
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = rd_base + 32'(k);
            #1;
            chk({tag, " ic_valid"}, 64'(bus.ic_beat_valid), 64'(owner == 1));
            chk({tag, " dc_valid"}, 64'(bus.dc_beat_valid), 64'(owner == 2));
            chk({tag, " ic_done"}, 64'(bus.ic_done), 64'(owner == 1 && k == 7));
            chk({tag, " dc_done"}, 64'(bus.dc_done), 64'(owner == 2 && k == 7));
            if (owner == 1) begin
                chk({tag, " ic_rdata"}, 64'(bus.ic_rdata), 64'(rd_base + 32'(k)));
                chk({tag, " ic_beat"}, 64'(bus.ic_beat), 64'(k));
            end
            if (owner == 2) begin
                chk({tag, " dc_rdata"}, 64'(bus.dc_rdata), 64'(rd_base + 32'(k)));
                chk({tag, " dc_beat"}, 64'(bus.dc_beat), 64'(k));
            end
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (drop_reqs && k == 0) begin
                bus.ic_req = 1'b0;
                bus.dc_req = 1'b0;
            end
            #1;
            chk({tag, " gap_req"}, 64'(bus.mem_req), 64'(0));
        end
    endtask

    logic [255:0] line_a, line_b, line_c;

    initial begin
        checks = 0;
        errors = 0;
        for (int k = 0; k < 8; k++) begin
            line_a[k*32 +: 32] = 32'hC0DE_0000 + 32'(k);
            line_b[k*32 +: 32] = 32'hBEEF_0100 + 32'(k);
            line_c[k*32 +: 32] = 32'h5A5A_0200 + 32'(k);
        end
        reset         = 1'b0;
        bus.ic_req    = 1'b0;
        bus.ic_addr   = '0;
        bus.dc_req    = 1'b0;
        bus.dc_addr   = '0;
        bus.wb_valid  = 1'b0;
        bus.wb_addr   = '0;
        bus.wb_data   = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        #1;
        chk("rst_wb_ready", 64'(bus.wb_ready), 64'(1));
        chk("rst_mem_req", 64'(bus.mem_req), 64'(0));
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_done", 64'({bus.ic_done, bus.dc_done}), 64'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk); #1;

        // IC-only refill, requester drops after first beat
        bus.ic_req  = 1'b1;
        bus.ic_addr = 32'h0000_1234;
        run_line("ic", 32'h1220, 1'b0, 1, '0, 32'hA000_0000, 8, -1, 1'b1);
        chk("ic_idle_busy", 64'(bus.busy), 64'(0));

        // both fills requesting continuously
        bus.ic_req  = 1'b1;
        bus.ic_addr = 32'h0000_8010;
        bus.dc_req  = 1'b1;
        bus.dc_addr = 32'h0000_9004;
        run_line("both1", 32'h9000, 1'b0, 2, '0, 32'hB000_0000, 8, -1, 1'b0);
`ifdef ARB_RR_EN
        run_line("both2", 32'h8000, 1'b0, 1, '0, 32'hB100_0000, 8, -1, 1'b1);
`else
        run_line("both2", 32'h9000, 1'b0, 2, '0, 32'hB100_0000, 8, -1, 1'b1);
`endif

        // writeback and DC refill of the same line presented together
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 32'h0004_0040;
        bus.wb_data  = line_a;
        bus.dc_req   = 1'b1;
        bus.dc_addr  = 32'h0004_0040;
        #1;
        chk("wbdc_ready_pre", 64'(bus.wb_ready), 64'(1));
        @(negedge clk);
        bus.wb_valid = 1'b0;
        #1;
        chk("wbdc_ready_full", 64'(bus.wb_ready), 64'(0));
        run_line("wbdc_wb", 32'h0004_0040, 1'b1, 0, line_a, 32'h0, 8, -1, 1'b0);
        chk("wbdc_ready_back", 64'(bus.wb_ready), 64'(1));
        run_line("wbdc_dc", 32'h0004_0040, 1'b0, 2, '0, 32'hC000_0000, 8, -1, 1'b1);

        // memory stall on beat 3
        bus.ic_req  = 1'b1;
        bus.ic_addr = 32'h0000_2004;
        run_line("stall", 32'h2000, 1'b0, 1, '0, 32'hD000_0000, 8, 3, 1'b1);

        // second line offered while the buffer is full
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 32'h0000_5000;
        bus.wb_data  = line_b;
        @(negedge clk);
        bus.wb_addr  = 32'h0000_6008;
        bus.wb_data  = line_c;
        #1;
        chk("full_ready", 64'(bus.wb_ready), 64'(0));
        chk("full_busy", 64'(bus.busy), 64'(1));
        run_line("full_a", 32'h5000, 1'b1, 0, line_b, 32'h0, 8, -1, 1'b0);
        chk("full_ready_free", 64'(bus.wb_ready), 64'(1));
        @(negedge clk);
        bus.wb_valid = 1'b0;
        #1;
        chk("full_ready_b", 64'(bus.wb_ready), 64'(0));
        run_line("full_b", 32'h6000, 1'b1, 0, line_c, 32'h0, 8, -1, 1'b0);
        chk("full_end_busy", 64'(bus.busy), 64'(0));

        // reset at beat 4 of a DC fill with a line buffered
        bus.dc_req  = 1'b1;
        bus.dc_addr = 32'h0000_3008;
        run_line("rstdc", 32'h3000, 1'b0, 2, '0, 32'hE000_0000, 4, -1, 1'b0);
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 32'h0000_7000;
        bus.wb_data  = line_a;
        @(negedge clk);
        bus.wb_valid = 1'b0;
        #1;
        chk("rstdc_buffered", 64'(bus.wb_ready), 64'(0));
        chk("rstdc_beat4_req", 64'(bus.mem_req), 64'(1));
        chk("rstdc_beat4_addr", 64'(bus.mem_addr), 64'(32'h3010));
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hE000_0004;
        reset = 1'b0;
        #1;
        chk("rstdc_req", 64'(bus.mem_req), 64'(0));
        chk("rstdc_addr", 64'(bus.mem_addr), 64'(0));
        chk("rstdc_valid", 64'(bus.dc_beat_valid), 64'(0));
        chk("rstdc_done", 64'(bus.dc_done), 64'(0));
        chk("rstdc_rdata", 64'(bus.dc_rdata), 64'(0));
        chk("rstdc_ready", 64'(bus.wb_ready), 64'(1));
        chk("rstdc_busy", 64'(bus.busy), 64'(0));
        bus.dc_req  = 1'b0;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        bus.dc_req = 1'b1;
        #1;
        run_line("rstdc_again", 32'h3000, 1'b0, 2, '0, 32'hF000_0000, 8, -1, 1'b1);
        @(negedge clk); #1;
        chk("rstdc_no_wb", 64'(bus.busy), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
